// File: rtl/turret_aim_ctrl_if.sv
// Aim-controller bundle: done/k_hat from the TDOA engine in, servo drive and re-arm status out.
// Combinational wiring only; done is a one-cycle pulse with no backpressure (ignored while busy).
interface turret_aim_ctrl_if #(
    parameter int W = 21
);
    logic              done;
    logic signed [7:0] k_hat;
    logic              servo_pwm;
    logic              restart;
    logic              busy;
    logic [W-1:0]      pulse_width;

    modport master (
        output done, k_hat,
        input  servo_pwm, restart, busy, pulse_width
    );

    modport slave (
        input  done, k_hat,
        output servo_pwm, restart, busy, pulse_width
    );
endinterface

// File: rtl/turret_aim_ctrl.sv
// Steps the servo pulse width by each k_hat, drives frame-aligned PWM, then re-arms capture/TDOA.
// All outputs registered (1-cycle); done arriving while busy is dropped, nothing is queued.
module turret_aim_ctrl #(
    parameter int T_MAX          = 42,
    parameter int PERIOD_CYCLES  = 2_000_000,
    parameter int CENTER_CYCLES  = 150_000,
    parameter int MIN_CYCLES     = 100_000,
    parameter int MAX_CYCLES     = 200_000,
    parameter int STEP_CYCLES    = 500,
    parameter int DIR            = 1,
    parameter int DEADBAND       = 1,
    parameter int SETTLE_FRAMES  = 25,
    parameter int RESTART_CYCLES = 4
) (
    input  logic             i_clock,
    input  logic             i_reset,
    turret_aim_ctrl_if.slave io_aim
);
    localparam int W  = $clog2(PERIOD_CYCLES + 1);
    localparam int SW = $clog2(SETTLE_FRAMES + 2);
    localparam int RW = $clog2(RESTART_CYCLES + 1);

    localparam logic signed [7:0]   TMAX_S = 8'(T_MAX);
    localparam logic signed [7:0]   DB_S   = 8'(DEADBAND);
    localparam logic signed [W+8:0] STEP_S = (W+9)'(STEP_CYCLES);
    localparam logic signed [W+8:0] MIN_S  = (W+9)'(MIN_CYCLES);
    localparam logic signed [W+8:0] MAX_S  = (W+9)'(MAX_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UPDATE,
        S_SETTLE,
        S_RESTART_HI,
        S_RESTART_LO
    } state_t;

    state_t            r_state;
    logic [W-1:0]      r_frame_cnt;
    logic [W-1:0]      r_pulse_width;
    logic [W-1:0]      r_pend_width;
    logic              r_servo_pwm;
    logic              r_restart;
    logic              r_busy;
    logic signed [7:0] r_kc;
    logic [SW-1:0]     r_wrap_cnt;
    logic [RW-1:0]     r_rst_cnt;

    logic              w_wrap;
    logic signed [7:0] w_k_clamped;
    logic              w_in_deadband;
    logic signed [W+8:0] w_kc_wide;
    logic signed [W+8:0] w_delta;
    logic signed [W+8:0] w_sum;
    logic [W-1:0]      w_next_pend;

    assign w_wrap        = (r_frame_cnt == W'(PERIOD_CYCLES - 1));
    assign w_in_deadband = (r_kc <= DB_S) && (r_kc >= -DB_S);
    assign w_kc_wide     = (W+9)'(r_kc);

    always_comb begin
        w_k_clamped = io_aim.k_hat;
        if (io_aim.k_hat > TMAX_S) begin
            w_k_clamped = TMAX_S;
        end else if (io_aim.k_hat < -TMAX_S) begin
            w_k_clamped = -TMAX_S;
        end
    end

    // Sum carried W+9 bits signed so the clamp sees the true target, never a wrapped one.
    always_comb begin
        w_delta = w_kc_wide * STEP_S;
        if (DIR < 0) begin
            w_delta = -(w_kc_wide * STEP_S);
        end
        w_sum       = $signed({9'b0, r_pend_width}) + w_delta;
        w_next_pend = w_sum[W-1:0];
        if (w_sum < MIN_S) begin
            w_next_pend = W'(MIN_CYCLES);
        end else if (w_sum > MAX_S) begin
            w_next_pend = W'(MAX_CYCLES);
        end
    end

    // Width only changes at the frame boundary, so every frame is a whole pulse.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_frame_cnt   <= '0;
            r_servo_pwm   <= 1'b0;
            r_pulse_width <= W'(CENTER_CYCLES);
        end else begin
            r_servo_pwm <= (r_frame_cnt < r_pulse_width);
            if (w_wrap) begin
                r_frame_cnt   <= '0;
                r_pulse_width <= r_pend_width;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_pend_width <= W'(CENTER_CYCLES);
            r_restart    <= 1'b0;
            r_busy       <= 1'b0;
            r_kc         <= '0;
            r_wrap_cnt   <= '0;
            r_rst_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_aim.done) begin
                        r_kc    <= w_k_clamped;
                        r_state <= S_UPDATE;
                        r_busy  <= 1'b1;
                    end
                end
                S_UPDATE: begin
                    r_wrap_cnt <= '0;
                    r_rst_cnt  <= '0;
                    if (w_in_deadband) begin
                        r_state   <= S_RESTART_HI;
                        r_restart <= 1'b1;
                    end else begin
                        r_pend_width <= w_next_pend;
                        r_state      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    // First wrap here applies the new width; settle frames are counted after it.
                    if (w_wrap) begin
                        if (r_wrap_cnt == SW'(SETTLE_FRAMES)) begin
                            r_state   <= S_RESTART_HI;
                            r_restart <= 1'b1;
                            r_rst_cnt <= '0;
                        end else begin
                            r_wrap_cnt <= r_wrap_cnt + 1'b1;
                        end
                    end
                end
                S_RESTART_HI: begin
                    if (r_rst_cnt == RW'(RESTART_CYCLES - 1)) begin
                        r_state   <= S_RESTART_LO;
                        r_restart <= 1'b0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end
                S_RESTART_LO: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_restart <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign io_aim.servo_pwm   = r_servo_pwm;
    assign io_aim.restart     = r_restart;
    assign io_aim.busy        = r_busy;
    assign io_aim.pulse_width = r_pulse_width;

endmodule

// File: tb/tb_turret_aim_ctrl.sv
// Bench for turret_aim_ctrl: directed and random done/k_hat traffic against a schedule-based model.
module tb_turret_aim_ctrl;
    localparam int P       = 100;
    localparam int CEN     = 50;
    localparam int MINW    = 20;
    localparam int MAXW    = 80;
    localparam int STEP    = 1;
    localparam int DIRV    = 1;
    localparam int DB      = 1;
    localparam int SETTLE  = 2;
    localparam int RSTC    = 4;
    localparam int TMAX    = 42;
    localparam int W       = $clog2(P + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    turret_aim_ctrl_if #(.W(W)) aim();

    turret_aim_ctrl #(
        .T_MAX(TMAX), .PERIOD_CYCLES(P), .CENTER_CYCLES(CEN), .MIN_CYCLES(MINW),
        .MAX_CYCLES(MAXW), .STEP_CYCLES(STEP), .DIR(DIRV), .DEADBAND(DB),
        .SETTLE_FRAMES(SETTLE), .RESTART_CYCLES(RSTC)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .io_aim (aim)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Model: edge index since reset; events are scheduled as absolute edge numbers.
    bit m_valid = 1'b0;
    int m_n, m_width, m_pend, m_pend_new, m_pend_edge;
    int m_bs, m_bl, m_rs;
    int exp_servo;
    int kc, tgt, w1;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_valid     = 1'b1;
                m_n         = 0;
                m_width     = CEN;
                m_pend      = CEN;
                m_pend_edge = -1;
                m_bs        = -100;
                m_bl        = -100;
                m_rs        = -100;
                exp_servo   = 0;
            end else if (m_valid) begin
                m_n++;
                exp_servo = (((m_n - 1) % P) < m_width) ? 1 : 0;
                if (m_n % P == 0) m_width = m_pend;
                if (m_n == m_pend_edge) m_pend = m_pend_new;
                if (aim.done && !(m_bs <= m_n - 1 && m_n - 1 < m_bl)) begin
                    kc = aim.k_hat;
                    if (kc > TMAX) kc = TMAX;
                    if (kc < -TMAX) kc = -TMAX;
                    if (kc <= DB && kc >= -DB) begin
                        m_rs = m_n + 1;
                    end else begin
                        tgt = m_pend + DIRV * kc * STEP;
                        if (tgt < MINW) tgt = MINW;
                        if (tgt > MAXW) tgt = MAXW;
                        m_pend_new  = tgt;
                        m_pend_edge = m_n + 1;
                        w1   = ((m_n + 2 + P - 1) / P) * P;
                        m_rs = w1 + P * SETTLE;
                    end
                    m_bs = m_n;
                    m_bl = m_rs + RSTC + 1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("servo_pwm", 32'(aim.servo_pwm), 32'(exp_servo));
                check("restart", 32'(aim.restart), 32'((m_rs <= m_n) && (m_n < m_rs + RSTC)));
                check("busy", 32'(aim.busy), 32'((m_bs <= m_n) && (m_n < m_bl)));
                check("pulse_width", 32'(aim.pulse_width), 32'(m_width));
            end
        end
    end

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic pulse_done(input logic signed [7:0] k);
        aim.done  = 1'b1;
        aim.k_hat = k;
        @(negedge clk);
        aim.done  = 1'b0;
        aim.k_hat = 8'($urandom);
    endtask

    task automatic wait_idle();
        int cnt = 0;
        while (aim.busy !== 1'b0 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 2000) check("idle_timeout", 32'(aim.busy), 32'd0);
    endtask

    initial begin
        int cnt;
        int t;
        logic signed [7:0] k;
        rst       = 1'b1;
        aim.done  = 1'b0;
        aim.k_hat = '0;
        tick(3);
        rst = 1'b0;
        tick(300);

        pulse_done(8'sd10);  wait_idle(); tick(5);
        pulse_done(8'sd1);   wait_idle(); tick(3);
        pulse_done(8'sd100); wait_idle();
        pulse_done(-8'sd128); wait_idle();
        pulse_done(-8'sd128); wait_idle();

        pulse_done(8'sd5); tick(20);
        pulse_done(-8'sd30); wait_idle();

        pulse_done(8'sd0);
        cnt = 0;
        while (aim.restart !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 20) check("restart_timeout", 32'(aim.restart), 32'd1);
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(4);

        rst       = 1'b1;
        aim.done  = 1'b1;
        aim.k_hat = 8'sd20;
        tick(1);
        rst      = 1'b0;
        aim.done = 1'b0;
        tick(10);
        pulse_done(-8'sd7); wait_idle();

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) begin
                t = int'($urandom_range(0, 6)) - 3;
                k = 8'(t);
            end else begin
                k = 8'($urandom);
            end
            pulse_done(k);
            tick(int'($urandom_range(1, 500)));
        end
        wait_idle();
        tick(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
